// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_f,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_f,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic [15:0]      op_count
);

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             last_grant_q, last_grant_d;

  logic             can_issue;
  logic             pick1;
  logic             xfer;

  // Arbitration: the response slot must be free (or draining) and reset must be low;
  // on contention the requester not served last wins.
  always_comb begin
    can_issue = !reset && (!rsp_valid_q || rsp_ready);
    if (req0_valid && req1_valid) begin
      pick1 = !last_grant_q;
    end else begin
      pick1 = req1_valid;
    end
    xfer       = can_issue && (req0_valid || req1_valid);
    req0_ready = xfer && !pick1;
    req1_ready = xfer && pick1;
  end

  // Steer the winner's operands onto the shared ALU; idle the ALU inputs when nothing is issued.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_f = 3'd0;
    if (xfer) begin
      alu_a = pick1 ? req1_a : req0_a;
      alu_b = pick1 ? req1_b : req0_b;
      alu_f = pick1 ? req1_f : req0_f;
    end
  end

  // Response register next-state: load on issue, drop when consumed, otherwise hold.
  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_y_d       = rsp_y_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    op_count_d    = op_count_q;
    last_grant_d  = last_grant_q;
    if (xfer) begin
      rsp_valid_d   = 1'b1;
      rsp_id_d      = pick1;
      rsp_y_d       = alu_y;
      rsp_zero_d    = alu_zero;
      rsp_illegal_d = (alu_f == 3'd3) || (alu_f == 3'd4) || (alu_f == 3'd5);
      op_count_d    = op_count_q + 16'd1;
      last_grant_d  = pick1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State flops; reset leaves last_grant at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_y_q       <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      op_count_q    <= 16'd0;
      last_grant_q  <= 1'b1;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_y_q       <= rsp_y_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
      op_count_q    <= op_count_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_illegal = rsp_illegal_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_f, req1_f;
  logic [W-1:0]  alu_a, alu_b, alu_y;
  logic [2:0]    alu_f;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;
  logic [W-1:0]  rsp_y;
  logic [15:0]   op_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_zero(rsp_zero),
    .rsp_illegal(rsp_illegal), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] f);
    case (f)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a | b);
      3'd5:    return a << b[4:0];
      3'd6:    return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Shared ALU seen by the DUT
  always_comb begin
    alu_y    = alu_fn(alu_a, alu_b, alu_f);
    alu_zero = (alu_y == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one response slot, round-robin memory, op counter
  logic          m_valid, m_id, m_zero, m_ill, m_last;
  logic [W-1:0]  m_y;
  logic [15:0]   m_count;

  // returns {someone_wants, winner_index}
  function automatic logic [1:0] choose(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return {1'b1, ~last};
    if (v0)       return 2'b10;
    if (v1)       return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_id <= 1'b0; m_y <= '0; m_zero <= 1'b0; m_ill <= 1'b0;
      m_count <= 16'd0; m_last <= 1'b1;
    end else begin
      logic [1:0] c;
      logic [W-1:0] y;
      logic [2:0] f;
      c = choose(req0_valid, req1_valid, m_last);
      if (c[1] && (!m_valid || rsp_ready)) begin
        f = c[0] ? req1_f : req0_f;
        y = c[0] ? alu_fn(req1_a, req1_b, req1_f) : alu_fn(req0_a, req0_b, req0_f);
        m_valid <= 1'b1;
        m_id    <= c[0];
        m_y     <= y;
        m_zero  <= (y == '0);
        m_ill   <= (f >= 3'd3) && (f <= 3'd5);
        m_count <= m_count + 16'd1;
        m_last  <= c[0];
      end else if (rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle compare of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] c;
      logic go;
      c  = choose(req0_valid, req1_valid, m_last);
      go = !reset && c[1] && (!m_valid || rsp_ready);
      check("req0_ready", req0_ready, go && !c[0]);
      check("req1_ready", req1_ready, go && c[0]);
      check("alu_a", alu_a, go ? (c[0] ? req1_a : req0_a) : '0);
      check("alu_b", alu_b, go ? (c[0] ? req1_b : req0_b) : '0);
      check("alu_f", alu_f, go ? (c[0] ? req1_f : req0_f) : 3'd0);
      check("rsp_valid", rsp_valid, m_valid);
      check("rsp_id", rsp_id, m_id);
      check("rsp_y", rsp_y, m_y);
      check("rsp_zero", rsp_zero, m_zero);
      check("rsp_illegal", rsp_illegal, m_ill);
      check("op_count", op_count, m_count);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_f = 0; req1_a = 0; req1_b = 0; req1_f = 0;
    #2 reset = 1'b1;
    #1;
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_op_count", op_count, 16'd0);
    check("reset_rsp_y", rsp_y, 32'd0);
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;

    // single req0 add
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_f = 2; rsp_ready = 1;
    @(negedge clk);
    check("first_req0_ready", req0_ready, 1'b1);
    cyc();
    req0_valid = 0;
    @(negedge clk);
    check("add_rsp_valid", rsp_valid, 1'b1);
    check("add_rsp_id", rsp_id, 1'b0);
    check("add_rsp_y", rsp_y, 32'd8);
    check("add_rsp_zero", rsp_zero, 1'b0);
    check("add_op_count", op_count, 16'd1);

    // round-robin alternation from a fresh reset
    cyc();
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_a = 10; req1_a = 20; req0_b = 1; req1_b = 2;
    req0_f = 2; req1_f = 2; rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_req0_ready", req0_ready, (i % 2) == 0);
      check("rr_req1_ready", req1_ready, (i % 2) == 1);
      if (i > 0) check("rr_rsp_id", rsp_id, (i - 1) % 2);
      cyc();
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    check("rr_last_id", rsp_id, 1'b1);
    check("rr_op_count", op_count, 16'd4);

    // backpressure hold
    cyc();
    req1_valid = 1; req1_a = 7; req1_b = 7; req1_f = 6; rsp_ready = 1;
    cyc();
    req1_valid = 0; rsp_ready = 0;
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_f = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req0_ready", req0_ready, 1'b0);
      check("bp_req1_ready", req1_ready, 1'b0);
      check("bp_rsp_y", rsp_y, 32'd0);
      check("bp_rsp_zero", rsp_zero, 1'b1);
      check("bp_rsp_id", rsp_id, 1'b1);
      cyc();
    end
    rsp_ready = 1;
    @(negedge clk);
    check("bp_release_ready", req0_ready, 1'b1);
    cyc();
    req0_valid = 0;
    @(negedge clk);
    check("bp_next_y", rsp_y, 32'd3);

    // illegal flag then signed compare
    cyc();
    req0_valid = 1; req0_a = 32'h55; req0_b = 32'h0F; req0_f = 4;
    cyc();
    req0_a = 32'hFFFF_FFFF; req0_b = 1; req0_f = 7;
    @(negedge clk);
    check("ill_flag", rsp_illegal, 1'b1);
    cyc();
    req0_valid = 0;
    @(negedge clk);
    check("slt_y", rsp_y, 32'd1);
    check("slt_illegal", rsp_illegal, 1'b0);

    // randomized traffic with occasional reset
    cyc();
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 149) == 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      req0_f = 3'($urandom_range(0, 7)); req1_f = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    reset = 0; req0_valid = 0; req1_valid = 0;

    // counter wrap over 0x10000 transfers, then asynchronous reset with a pending response
    do_reset();
    req0_valid = 1; req0_a = 32'h1234; req0_b = 1; req0_f = 2; rsp_ready = 1;
    repeat (16'hFFFF) cyc();
    @(negedge clk);
    check("cnt_ffff", op_count, 16'hFFFF);
    cyc();
    @(negedge clk);
    check("cnt_wrap", op_count, 16'h0000);
    check("wrap_rsp_valid", rsp_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rsp_valid", rsp_valid, 1'b0);
    check("async_rsp_y", rsp_y, 32'd0);
    check("async_no_ready", req0_ready, 1'b0);
    cyc();
    reset = 0; req1_valid = 1;
    @(negedge clk);
    check("post_reset_req0_wins", req0_ready, 1'b1);
    cyc();
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    check("post_reset_count", op_count, 16'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
